// File: rtl/traffic_light_ctrl.sv
// Sequencing FSM for a two-yellow traffic light with latched pedestrian request
// and blinking-yellow night mode; times each phase from an external seconds timer.
module traffic_light_ctrl #(
  parameter int BIT      = 5,
  parameter int T_RED    = 10,
  parameter int T_RY     = 2,
  parameter int T_GREEN  = 10,
  parameter int T_GMIN   = 4,
  parameter int T_GBLINK = 3,
  parameter int T_YEL    = 3
) (
  input  logic         clk_50MHz,
  input  logic         res,
  input  logic [BIT:0] sec_cnt,
  input  logic         clk_1Hz,
  input  logic         ped_req,
  input  logic         night,
  output logic         load,
  output logic         red,
  output logic         yellow,
  output logic         green,
  output logic         ped_green,
  output logic [2:0]   state
);

  localparam int W = BIT + 1;
  localparam logic [BIT:0] LIM_RED    = W'(T_RED);
  localparam logic [BIT:0] LIM_RY     = W'(T_RY);
  localparam logic [BIT:0] LIM_GREEN  = W'(T_GREEN);
  localparam logic [BIT:0] LIM_GMIN   = W'(T_GMIN);
  localparam logic [BIT:0] LIM_GBLINK = W'(T_GBLINK);
  localparam logic [BIT:0] LIM_YEL    = W'(T_YEL);

  typedef enum logic [2:0] {
    S_RED         = 3'd0,
    S_RED_YELLOW  = 3'd1,
    S_GREEN       = 3'd2,
    S_GREEN_BLINK = 3'd3,
    S_YELLOW      = 3'd4,
    S_NIGHT       = 3'd5
  } state_e;

  // State register kept as raw bits so codes 6/7 remain representable and recoverable.
  logic [2:0]   state_q;
  state_e       state_cur;
  state_e       state_d;
  logic         load_q, load_d;
  logic         pend_q, pend_d;
  logic [3:0]   lamps_q, lamps_d;  // {red, yellow, green, ped_green}
  logic [BIT:0] limit;
  logic         timed_out;
  logic         ped_cut;

  assign state_cur = state_e'(state_q);

  always_comb begin
    limit = LIM_RED;
    case (state_cur)
      S_RED:         limit = LIM_RED;
      S_RED_YELLOW:  limit = LIM_RY;
      S_GREEN:       limit = LIM_GREEN;
      S_GREEN_BLINK: limit = LIM_GBLINK;
      S_YELLOW:      limit = LIM_YEL;
      default:       limit = LIM_RED;
    endcase
  end

  assign timed_out = load_q && (sec_cnt >= limit);
  assign ped_cut   = load_q && pend_q && (sec_cnt >= LIM_GMIN);

  always_comb begin
    state_d = state_cur;
    case (state_cur)
      S_RED:         if (timed_out) state_d = night ? S_NIGHT : S_RED_YELLOW;
      S_RED_YELLOW:  if (timed_out) state_d = S_GREEN;
      S_GREEN:       if (timed_out || ped_cut) state_d = S_GREEN_BLINK;
      S_GREEN_BLINK: if (timed_out) state_d = S_YELLOW;
      S_YELLOW:      if (timed_out) state_d = S_RED;
      S_NIGHT:       if (!night) state_d = S_RED;
      default:       state_d = S_RED;
    endcase

    // A one-clock load=0 pulse on every transition restarts the timer at 0.
    load_d = (state_d == state_cur);

    pend_d = pend_q;
    if (ped_req && (state_cur != S_RED) && (state_cur != S_NIGHT)) pend_d = 1'b1;
    if ((state_d == S_RED) && !load_d) pend_d = 1'b0;
  end

  always_comb begin
    lamps_d = 4'b0000;
    case (state_cur)
      S_RED:         lamps_d = 4'b1001;
      S_RED_YELLOW:  lamps_d = 4'b1100;
      S_GREEN:       lamps_d = 4'b0010;
      S_GREEN_BLINK: lamps_d = {2'b00, clk_1Hz, 1'b0};
      S_YELLOW:      lamps_d = 4'b0100;
      S_NIGHT:       lamps_d = {1'b0, clk_1Hz, 2'b00};
      default:       lamps_d = 4'b0000;
    endcase
  end

  always_ff @(posedge clk_50MHz) begin
    if (res) begin
      state_q <= S_RED;
      load_q  <= 1'b0;
      pend_q  <= 1'b0;
      lamps_q <= 4'b1000;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      pend_q  <= pend_d;
      lamps_q <= lamps_d;
    end
  end

  assign load      = load_q;
  assign red       = lamps_q[3];
  assign yellow    = lamps_q[2];
  assign green     = lamps_q[1];
  assign ped_green = lamps_q[0];
  assign state     = state_q;

endmodule
